// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the unified-memory arbiter: data/address widths,
// FSM state encodings and the fetch/data grant selection.
package mem_arbiter_pkg;

    localparam int WORD_SIZE  = 32;
    localparam int ADDR_WIDTH = 32;

    localparam logic [1:0] ARB_IDLE    = 2'd0;
    localparam logic [1:0] ARB_BUSY_IF = 2'd1;
    localparam logic [1:0] ARB_BUSY_DM = 2'd2;
    localparam logic [1:0] ARB_DRAIN   = 2'd3;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_IF   = 2'd1,
        GNT_DM   = 2'd2
    } arb_grant_e;

    // When both sides are pending, the one that did not win last time gets the slot.
    function automatic arb_grant_e arb_pick(input logic dm_pend,
                                            input logic if_pend,
                                            input logic last_dm);
        arb_grant_e g;
        g = GNT_NONE;
        if (dm_pend && (!if_pend || !last_dm)) begin
            g = GNT_DM;
        end else if (if_pend) begin
            g = GNT_IF;
        end
        return g;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of fetch, data-stage and memory-side signals around the arbiter.
// The arbiter uses the slave view; the surrounding pipeline/memory use master.
interface mem_arbiter_if #(
    parameter int WORD_SIZE  = mem_arbiter_pkg::WORD_SIZE,
    parameter int ADDR_WIDTH = mem_arbiter_pkg::ADDR_WIDTH
);

    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic                  if_cancel;
    logic [WORD_SIZE-1:0]  if_rdata;
    logic                  if_ready;

    logic                  dm_req;
    logic                  dm_we;
    logic [ADDR_WIDTH-1:0] dm_addr;
    logic [WORD_SIZE-1:0]  dm_wdata;
    logic [WORD_SIZE-1:0]  dm_rdata;
    logic                  dm_ready;

    logic                  stall_if;
    logic                  stall_dm;

    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [WORD_SIZE-1:0]  mem_wdata;
    logic                  mem_ack;
    logic [WORD_SIZE-1:0]  mem_rdata;

    modport slave (
        input  if_req, if_addr, if_cancel,
        input  dm_req, dm_we, dm_addr, dm_wdata,
        input  mem_ack, mem_rdata,
        output if_rdata, if_ready,
        output dm_rdata, dm_ready,
        output stall_if, stall_dm,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, if_cancel,
        output dm_req, dm_we, dm_addr, dm_wdata,
        output mem_ack, mem_rdata,
        input  if_rdata, if_ready,
        input  dm_rdata, dm_ready,
        input  stall_if, stall_dm,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_arbiter.sv
// Serialises instruction-fetch and load/store requests onto one single-ported,
// variable-latency memory with at most one transaction outstanding.
module mem_arbiter #(
    parameter int WORD_SIZE  = mem_arbiter_pkg::WORD_SIZE,
    parameter int ADDR_WIDTH = mem_arbiter_pkg::ADDR_WIDTH
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);
    import mem_arbiter_pkg::*;

    logic [1:0]            state_q, state_d;
    logic                  last_dm_q, last_dm_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [WORD_SIZE-1:0]  mem_wdata_q, mem_wdata_d;

    arb_grant_e            grant;
    logic                  if_done;
    logic                  dm_done;

    // A redirect in the same cycle blocks a fresh fetch grant.
    assign grant = arb_pick(bus.dm_req, bus.if_req & ~bus.if_cancel, last_dm_q);

    // Gated by reset so an abandoned transaction never reports completion.
    assign if_done = rst & (state_q == ARB_BUSY_IF) & bus.mem_ack & ~bus.if_cancel;
    assign dm_done = rst & (state_q == ARB_BUSY_DM) & bus.mem_ack;

    assign bus.if_ready  = if_done;
    assign bus.dm_ready  = dm_done;
    assign bus.if_rdata  = if_done ? bus.mem_rdata : '0;
    assign bus.dm_rdata  = dm_done ? bus.mem_rdata : '0;

    assign bus.stall_if  = bus.if_req & ~if_done & ~bus.if_cancel;
    assign bus.stall_dm  = bus.dm_req & ~dm_done;

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

    always_comb begin
        state_d     = state_q;
        last_dm_d   = last_dm_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            ARB_IDLE: begin
                case (grant)
                    GNT_DM: begin
                        state_d     = ARB_BUSY_DM;
                        last_dm_d   = 1'b1;
                        mem_req_d   = 1'b1;
                        mem_we_d    = bus.dm_we;
                        mem_addr_d  = bus.dm_addr;
                        mem_wdata_d = bus.dm_wdata;
                    end
                    GNT_IF: begin
                        state_d     = ARB_BUSY_IF;
                        last_dm_d   = 1'b0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = bus.if_addr;
                        mem_wdata_d = '0;
                    end
                    default: begin
                        state_d = ARB_IDLE;
                    end
                endcase
            end

            ARB_BUSY_IF: begin
                // An ack wins over a redirect; the redirect only hides the ready.
                if (bus.mem_ack) begin
                    state_d   = ARB_IDLE;
                    mem_req_d = 1'b0;
                end else if (bus.if_cancel) begin
                    state_d   = ARB_DRAIN;
                end
            end

            ARB_BUSY_DM: begin
                if (bus.mem_ack) begin
                    state_d   = ARB_IDLE;
                    mem_req_d = 1'b0;
                end
            end

            ARB_DRAIN: begin
                if (bus.mem_ack) begin
                    state_d   = ARB_IDLE;
                    mem_req_d = 1'b0;
                end
            end

            default: begin
                state_d   = ARB_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ARB_IDLE;
            last_dm_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            last_dm_q   <= last_dm_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a transaction-level model predicts grants,
// completions and stalls; a monitor compares them against the arbiter outputs.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst;

    mem_arbiter_if #(.WORD_SIZE(32), .ADDR_WIDTH(32)) bus ();

    mem_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct { bit req; bit ifr; bit dmr; bit sif; bit sdm; } cyc_t;
    typedef struct { bit we; logic [31:0] addr; logic [31:0] wdata; } gnt_t;
    typedef struct { bit is_dm; logic [31:0] data; } rdy_t;

    cyc_t cyc_q[$];
    gnt_t gnt_q[$];
    rdy_t rdy_q[$];

    int vectors     = 0;
    int miscompares = 0;

    // Transaction-level model of the arbiter.
    bit m_busy, m_dm, m_killed, m_last_dm;
    int m_wait;

    bit          last_ifr, last_dmr, last_cancel;
    int          lat_force;
    logic [31:0] rdata_force;
    bit          spur_en, spur_force, dead_mode;
    int          p_if, p_dm, p_cancel;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle: memory responds, model predicts, expectations are queued.
    task automatic cycle();
        bit          ack, dm_p, if_p, win_dm;
        logic [31:0] rd;
        cyc_t        c;
        rdy_t        r;
        gnt_t        g;

        ack = 1'b0;
        if (m_busy && m_wait == 1) ack = 1'b1;
        else if (!m_busy && (spur_force || (spur_en && $urandom_range(0, 7) == 0))) ack = 1'b1;
        rd = (ack && m_busy && rdata_force != 0) ? rdata_force : $urandom;
        bus.mem_ack   = ack;
        bus.mem_rdata = rd;

        c.req = m_busy;
        c.ifr = rst && m_busy && ack && !m_dm && !m_killed && !bus.if_cancel;
        c.dmr = rst && m_busy && ack && m_dm;
        c.sif = bus.if_req && !c.ifr && !bus.if_cancel;
        c.sdm = bus.dm_req && !c.dmr;
        cyc_q.push_back(c);
        if (c.ifr || c.dmr) begin
            r.is_dm = c.dmr;
            r.data  = rd;
            rdy_q.push_back(r);
        end
        last_ifr    = c.ifr;
        last_dmr    = c.dmr;
        last_cancel = bus.if_cancel;

        if (!rst) begin
            m_busy    = 1'b0;
            m_last_dm = 1'b0;
        end else if (m_busy) begin
            if (ack) begin
                m_busy = 1'b0;
            end else begin
                m_wait--;
                if (!m_dm && bus.if_cancel) m_killed = 1'b1;
            end
        end else begin
            dm_p = bus.dm_req;
            if_p = bus.if_req && !bus.if_cancel;
            if (dm_p || if_p) begin
                win_dm    = (dm_p && if_p) ? !m_last_dm : dm_p;
                m_busy    = 1'b1;
                m_dm      = win_dm;
                m_killed  = 1'b0;
                m_last_dm = win_dm;
                m_wait    = (lat_force != 0) ? lat_force : int'($urandom_range(1, 4));
                g.we      = win_dm ? bus.dm_we : 1'b0;
                g.addr    = win_dm ? bus.dm_addr : bus.if_addr;
                g.wdata   = bus.dm_wdata;
                gnt_q.push_back(g);
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Requesters hold until their ready, then drop or issue a new request.
    task automatic agents();
        if (last_ifr || last_cancel || !bus.if_req) begin
            bus.if_req  = ($urandom_range(0, 99) < p_if);
            bus.if_addr = 32'h1000 | ($urandom_range(0, 1023) << 2);
        end
        bus.if_cancel = ($urandom_range(0, 99) < p_cancel);
        if (last_dmr || !bus.dm_req) begin
            bus.dm_req   = ($urandom_range(0, 99) < p_dm);
            bus.dm_we    = $urandom_range(0, 1) == 1;
            bus.dm_addr  = 32'h2000 | ($urandom_range(0, 1023) << 2);
            bus.dm_wdata = dead_mode ? 32'hDEADBEEF : $urandom;
        end
    endtask

    task automatic run_auto(input int n);
        for (int i = 0; i < n; i++) begin
            agents();
            cycle();
        end
    endtask

    // Monitor: compares every cycle and pops transaction queues on grants/readies.
    initial begin
        cyc_t c;
        rdy_t r;
        gnt_t cur;
        bit   prev_req;
        prev_req = 1'b0;
        cur.we = 1'b0; cur.addr = '0; cur.wdata = '0;
        forever begin
            @(negedge clk);
            if (cyc_q.size() != 0) begin
                c = cyc_q.pop_front();
                check("mem_req",  32'(bus.mem_req),  32'(c.req));
                check("if_ready", 32'(bus.if_ready), 32'(c.ifr));
                check("dm_ready", 32'(bus.dm_ready), 32'(c.dmr));
                check("stall_if", 32'(bus.stall_if), 32'(c.sif));
                check("stall_dm", 32'(bus.stall_dm), 32'(c.sdm));
                if (bus.mem_req && !prev_req) begin
                    if (gnt_q.size() == 0) begin
                        check("grant_queue", 32'(gnt_q.size()), 32'd1);
                    end else begin
                        cur = gnt_q.pop_front();
                        check("mem_we",   32'(bus.mem_we), 32'(cur.we));
                        check("mem_addr", bus.mem_addr, cur.addr);
                        if (cur.we) check("mem_wdata", bus.mem_wdata, cur.wdata);
                    end
                end else if (bus.mem_req && prev_req) begin
                    check("mem_addr_stable", bus.mem_addr, cur.addr);
                    check("mem_we_stable", 32'(bus.mem_we), 32'(cur.we));
                end
                if (bus.if_ready || bus.dm_ready) begin
                    if (rdy_q.size() == 0) begin
                        check("ready_queue", 32'(rdy_q.size()), 32'd1);
                    end else begin
                        r = rdy_q.pop_front();
                        if (r.is_dm) check("dm_rdata", bus.dm_rdata, r.data);
                        else         check("if_rdata", bus.if_rdata, r.data);
                    end
                end
                if (!bus.if_ready) check("if_rdata_zero", bus.if_rdata, 32'd0);
                if (!bus.dm_ready) check("dm_rdata_zero", bus.dm_rdata, 32'd0);
                prev_req = bus.mem_req;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        bus.if_req = 1'b1; bus.if_addr = 32'h40; bus.if_cancel = 1'b0;
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h100; bus.dm_wdata = '0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        m_busy = 0; m_dm = 0; m_killed = 0; m_last_dm = 0; m_wait = 0;
        last_ifr = 0; last_dmr = 0; last_cancel = 0;
        lat_force = 0; rdata_force = '0; spur_en = 0; spur_force = 0; dead_mode = 0;
        p_if = 0; p_dm = 0; p_cancel = 0;
        @(posedge clk);
        #1;

        // Reset with both requests pending, then data wins first.
        repeat (3) cycle();
        rst = 1'b1;
        run_auto(14);

        // Single fetch with a three-cycle memory.
        bus.if_req = 1'b1; bus.if_addr = 32'h40;
        lat_force = 3; rdata_force = 32'h00500093;
        run_auto(6);
        lat_force = 0; rdata_force = '0;

        // Continuous contention: grants alternate.
        p_if = 100; p_dm = 100; dead_mode = 1;
        run_auto(24);
        p_if = 0; p_dm = 0; dead_mode = 0;
        run_auto(12);

        // Redirect one cycle after a fetch grant; pending load waits for the drain.
        bus.if_req = 1'b1; bus.if_addr = 32'h80; lat_force = 3;
        cycle();
        bus.if_cancel = 1'b1; bus.if_req = 1'b0;
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h300;
        cycle();
        bus.if_cancel = 1'b0;
        run_auto(8);

        // Redirect coincident with the fetch ack.
        bus.if_req = 1'b1; bus.if_addr = 32'hC0; lat_force = 2;
        cycle();
        cycle();
        bus.if_cancel = 1'b1;
        cycle();
        bus.if_cancel = 1'b0; bus.if_req = 1'b0;
        cycle();
        lat_force = 0;

        // Redirect while idle blocks that cycle's fetch grant.
        bus.if_req = 1'b1; bus.if_addr = 32'hE0; bus.if_cancel = 1'b1;
        cycle();
        bus.if_cancel = 1'b0;
        run_auto(8);

        // Reset in the middle of a store, then a stray ack.
        bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 32'h500;
        bus.dm_wdata = 32'hDEADBEEF; lat_force = 4;
        cycle();
        cycle();
        rst = 1'b0;
        cycle();
        rst = 1'b1; bus.dm_req = 1'b0; spur_force = 1'b1;
        cycle();
        spur_force = 1'b0; lat_force = 0;
        run_auto(3);

        // Randomised traffic with redirects and stray acks.
        p_if = 60; p_dm = 50; p_cancel = 10; spur_en = 1;
        run_auto(600);
        p_if = 0; p_dm = 0; p_cancel = 0; spur_en = 0;
        run_auto(20);

        check("grants_left", 32'(gnt_q.size()), 32'd0);
        check("readies_left", 32'(rdy_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
